// File: rtl/cpu_issue_gate.sv
`default_nettype none
// ============================================================================
// cpu_issue_gate : decode-to-execute issue register with stack-hazard stall,
//                  shadow effect pipe and committed stack-depth tracking.
// Revision       : 1.0
// ============================================================================
module cpu_issue_gate #(
  parameter int IW          = 48,
  parameter int PCW         = 32,
  parameter int CW          = 2,
  parameter int DEPTH       = 3,
  parameter int MODE        = 0,
  parameter int STACK_DEPTH = 64,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_instr,
  input  logic [PCW-1:0] in_pc,
  input  logic [CW-1:0]  in_pop,
  input  logic [CW-1:0]  in_push,
  input  logic [1:0]     in_reads,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IW-1:0]  out_instr,
  output logic [PCW-1:0] out_pc,
  output logic [CW-1:0]  out_pop,
  output logic [CW-1:0]  out_push,
  input  logic           kill,
  output logic [DW-1:0]  st_depth,
  output logic           st_underflow,
  output logic           st_overflow,
  output logic           busy
);

  // Commit arithmetic is widened so pop/push larger than the depth field cannot wrap.
  localparam int SW = ((DW > CW) ? DW : CW) + 2;
  localparam logic [SW-1:0] C_MAX_X = SW'(STACK_DEPTH);
  localparam logic [DW-1:0] C_MAX   = DW'(STACK_DEPTH);

  logic [2*CW-1:0] r_flight [DEPTH];

  logic            w_fire;
  logic            w_accept;
  logic            w_flight_eff;
  logic            w_out_eff;
  logic            w_hazard;
  logic [CW-1:0]   w_cp;
  logic [CW-1:0]   w_cq;
  logic [SW-1:0]   w_depth_x;
  logic [SW-1:0]   w_pop_x;
  logic [SW-1:0]   w_pop_eff;
  logic [SW-1:0]   w_sum;
  logic            w_under;
  logic            w_over;
  logic [DW-1:0]   w_depth_nx;

  // Only effectful instructions leave a nonzero entry in the shadow pipe.
  always_comb begin
    w_flight_eff = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_flight_eff = w_flight_eff | (r_flight[i] != '0);
    end
  end

  assign w_out_eff = out_valid && ((out_pop != '0) || (out_push != '0));
  assign w_hazard  = (w_flight_eff || w_out_eff) && ((MODE == 0) || (in_reads != 2'd0));
  assign in_ready  = (!out_valid || out_ready) && !w_hazard && !kill;
  assign w_accept  = in_valid && in_ready;
  assign w_fire    = out_valid && out_ready;
  assign busy      = out_valid || w_flight_eff;

  assign w_cp       = r_flight[DEPTH-1][2*CW-1:CW];
  assign w_cq       = r_flight[DEPTH-1][CW-1:0];
  assign w_depth_x  = SW'(st_depth);
  assign w_pop_x    = SW'(w_cp);
  assign w_under    = w_pop_x > w_depth_x;
  assign w_pop_eff  = w_under ? w_depth_x : w_pop_x;
  assign w_sum      = w_depth_x - w_pop_eff + SW'(w_cq);
  assign w_over     = w_sum > C_MAX_X;
  assign w_depth_nx = w_over ? C_MAX : w_sum[DW-1:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_pop   <= '0;
      out_push  <= '0;
    end else if (kill) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      out_pc    <= in_pc;
      out_pop   <= in_pop;
      out_push  <= in_push;
    end else if (w_fire) begin
      out_valid <= 1'b0;
    end
  end

  // The oldest entry is past the kill point, so it commits even on a kill edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_flight[i] <= '0;
      end
    end else begin
      r_flight[0] <= (w_fire && !kill) ? {out_pop, out_push} : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_flight[i] <= kill ? '0 : r_flight[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st_depth     <= '0;
      st_underflow <= 1'b0;
      st_overflow  <= 1'b0;
    end else begin
      st_depth <= w_depth_nx;
      if (w_under) st_underflow <= 1'b1;
      if (w_over)  st_overflow  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_issue_gate.sv
`default_nettype none
// ============================================================================
// tb_cpu_issue_gate : two configurations driven in lockstep and compared each
//                     cycle against an event-list stack model.
// Revision          : 1.0
// ============================================================================
module tb_cpu_issue_gate;

  localparam int IW  = 48;
  localparam int PCW = 32;
  localparam int CW  = 2;
  localparam int DW  = 3;

  typedef struct {
    int d;
    int due;
    int p;
    int q;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst_b = 1'b1;
  logic           in_valid;
  logic [IW-1:0]  in_instr;
  logic [PCW-1:0] in_pc;
  logic [CW-1:0]  in_pop;
  logic [CW-1:0]  in_push;
  logic [1:0]     in_reads;
  logic           out_ready;
  logic           kill;

  logic           rdy [2];
  logic           ov  [2];
  logic           uf  [2];
  logic           of  [2];
  logic           bsy [2];
  logic [IW-1:0]  oi  [2];
  logic [PCW-1:0] opc [2];
  logic [CW-1:0]  opop [2];
  logic [CW-1:0]  opush [2];
  logic [DW-1:0]  dep [2];

  int             n_checks = 0;
  int             n_errors = 0;
  int             edge_n   = 0;
  ev_t            pend[$];
  bit             m_ov   [2];
  logic [IW-1:0]  m_instr[2];
  logic [PCW-1:0] m_pc   [2];
  int             m_pop  [2];
  int             m_push [2];
  int             m_depth[2];
  bit             m_uf   [2];
  bit             m_of   [2];
  bit             e_rdy  [2];

  always #5 clk = ~clk;

  cpu_issue_gate #(.IW(IW), .PCW(PCW), .CW(CW), .DEPTH(3), .MODE(0), .STACK_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(rdy[0]), .in_instr(in_instr),
    .in_pc(in_pc), .in_pop(in_pop), .in_push(in_push), .in_reads(in_reads),
    .out_valid(ov[0]), .out_ready(out_ready), .out_instr(oi[0]), .out_pc(opc[0]),
    .out_pop(opop[0]), .out_push(opush[0]), .kill(kill), .st_depth(dep[0]),
    .st_underflow(uf[0]), .st_overflow(of[0]), .busy(bsy[0]));

  cpu_issue_gate #(.IW(IW), .PCW(PCW), .CW(CW), .DEPTH(4), .MODE(1), .STACK_DEPTH(6)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(rdy[1]), .in_instr(in_instr),
    .in_pc(in_pc), .in_pop(in_pop), .in_push(in_push), .in_reads(in_reads),
    .out_valid(ov[1]), .out_ready(out_ready), .out_instr(oi[1]), .out_pc(opc[1]),
    .out_pop(opop[1]), .out_push(opush[1]), .kill(kill), .st_depth(dep[1]),
    .st_underflow(uf[1]), .st_overflow(of[1]), .busy(bsy[1]));

  function automatic int depth_of(input int d);
    return (d == 0) ? 3 : 4;
  endfunction

  function automatic int mode_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int cap_of(input int d);
    return (d == 0) ? 4 : 6;
  endfunction

  // An effectful fire stays in flight until its commit edge has happened.
  function automatic bit in_flight(input int d);
    foreach (pend[i]) begin
      if (pend[i].d == d && pend[i].due > edge_n) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_ready(input int d);
    bit haz;
    haz = (in_flight(d) || (m_ov[d] && (m_pop[d] != 0 || m_push[d] != 0)))
          && (mode_of(d) == 0 || in_reads != 2'd0);
    return (!m_ov[d] || out_ready) && !haz && !kill;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("u%0d.out_valid", d), 64'(ov[d]), 64'(m_ov[d]));
      check($sformatf("u%0d.out_instr", d), 64'(oi[d]), 64'(m_instr[d]));
      check($sformatf("u%0d.out_pc", d), 64'(opc[d]), 64'(m_pc[d]));
      check($sformatf("u%0d.out_pop", d), 64'(opop[d]), 64'(m_pop[d]));
      check($sformatf("u%0d.out_push", d), 64'(opush[d]), 64'(m_push[d]));
      check($sformatf("u%0d.st_depth", d), 64'(dep[d]), 64'(m_depth[d]));
      check($sformatf("u%0d.underflow", d), 64'(uf[d]), 64'(m_uf[d]));
      check($sformatf("u%0d.overflow", d), 64'(of[d]), 64'(m_of[d]));
    end
  endtask

  task automatic commit(input int d, input int p, input int q);
    int pe;
    int r;
    pe = p;
    if (p > m_depth[d]) begin
      m_uf[d] = 1'b1;
      pe = m_depth[d];
    end
    r = m_depth[d] - pe + q;
    if (r > cap_of(d)) begin
      m_of[d] = 1'b1;
      r = cap_of(d);
    end
    m_depth[d] = r;
  endtask

  task automatic model_edge();
    bit acc;
    bit fire;
    ev_t ev;
    for (int d = 0; d < 2; d++) begin
      acc  = in_valid && e_rdy[d];
      fire = m_ov[d] && out_ready;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].d == d && pend[i].due == edge_n) begin
          commit(d, pend[i].p, pend[i].q);
          pend.delete(i);
        end else if (pend[i].d == d && kill && pend[i].due > edge_n) begin
          pend.delete(i);
        end
      end
      if (kill) begin
        m_ov[d] = 1'b0;
      end else begin
        if (fire && (m_pop[d] != 0 || m_push[d] != 0)) begin
          ev.d = d; ev.due = edge_n + depth_of(d); ev.p = m_pop[d]; ev.q = m_push[d];
          pend.push_back(ev);
        end
        if (acc) begin
          m_ov[d]    = 1'b1;
          m_instr[d] = in_instr;
          m_pc[d]    = in_pc;
          m_pop[d]   = int'(in_pop);
          m_push[d]  = int'(in_push);
        end else if (fire) begin
          m_ov[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      e_rdy[d] = exp_ready(d);
      check($sformatf("u%0d.in_ready", d), 64'(rdy[d]), 64'(e_rdy[d]));
      check($sformatf("u%0d.busy", d), 64'(bsy[d]), 64'(m_ov[d] || in_flight(d)));
    end
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic drive(input bit v, input int p, input int q, input int rd, input bit ordy, input bit k);
    in_valid  = v;
    in_pop    = CW'(p);
    in_push   = CW'(q);
    in_reads  = 2'(rd);
    out_ready = ordy;
    kill      = k;
    in_instr  = {16'($urandom), $urandom};
    in_pc     = $urandom;
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
    rst_b = 1'b0;
    #2;
    pend.delete();
    for (int d = 0; d < 2; d++) begin
      m_ov[d] = 1'b0; m_instr[d] = '0; m_pc[d] = '0; m_pop[d] = 0; m_push[d] = 0;
      m_depth[d] = 0; m_uf[d] = 1'b0; m_of[d] = 1'b0;
      check($sformatf("u%0d.rst_ready", d), 64'(rdy[d]), 64'd1);
      check($sformatf("u%0d.rst_busy", d), 64'(bsy[d]), 64'd0);
    end
    check_outs();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
      step();
    end
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
    #1;
    do_reset();

    // Single push followed by an effect-free instruction.
    drive(1'b1, 0, 1, 0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 0, 0, 0, 1'b1, 1'b0);
      step();
    end
    check("push1.depth_u0", 64'(dep[0]), 64'd1);
    check("push1.depth_u1", 64'(dep[1]), 64'd1);

    // Stream of non-reading pushes; relaxed mode issues every cycle and saturates.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 0, 1, 0, 1'b1, 1'b0);
      step();
    end
    idle(6);
    check("stream.depth_u1", 64'(dep[1]), 64'd6);
    check("stream.ovf_u1", 64'(of[1]), 64'd1);

    do_reset();
    drive(1'b1, 2, 0, 1, 1'b1, 1'b0);
    step();
    idle(7);
    check("undf.flag_u0", 64'(uf[0]), 64'd1);
    check("undf.depth_u0", 64'(dep[0]), 64'd0);

    do_reset();
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 0, 1, 2, 1'b1, 1'b0);
      step();
    end
    idle(6);
    check("ovf.flag_u0", 64'(of[0]), 64'd1);
    check("ovf.depth_u0", 64'(dep[0]), 64'd4);

    // Kill while several effects are in flight in the relaxed pipe.
    do_reset();
    drive(1'b1, 0, 1, 0, 1'b1, 1'b0); step();
    drive(1'b1, 0, 1, 0, 1'b1, 1'b0); step();
    drive(1'b1, 1, 0, 0, 1'b1, 1'b0); step();
    drive(1'b1, 0, 1, 0, 1'b1, 1'b0); step();
    drive(1'b1, 0, 1, 0, 1'b1, 1'b0); step();
    drive(1'b1, 0, 0, 0, 1'b1, 1'b1); step();
    check("kill.ov_u0", 64'(ov[0]), 64'd0);
    check("kill.ov_u1", 64'(ov[1]), 64'd0);
    idle(6);

    // Execute back-pressure, then release.
    drive(1'b1, 0, 0, 0, 1'b1, 1'b0); step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 0, 0, 0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 0, 0, 0, 1'b1, 1'b0);
      step();
    end

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 3) != 0,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0,
              int'($urandom_range(0, 2)),
              $urandom_range(0, 4) != 0,
              $urandom_range(0, 19) == 0);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
